// File: rtl/anubis_io_pkg.sv
// anubis_io_pkg: shared widths, core order codes and controller state encoding
package anubis_io_pkg;
    localparam int WORD_W = 32;
    localparam int BLK_W = 128;
    localparam logic [1:0] ORD_KEY = 2'b00;
    localparam logic [1:0] ORD_PT = 2'b01;
    localparam logic [1:0] ORD_RUN = 2'b10;
    typedef enum logic [2:0] {IDLE, CRST, KEYLD, PTLD, RUN, CAPT, DRAIN} state_t;
endpackage

// File: rtl/anubis_word_packer.sv
// anubis_word_packer: gathers four 32-bit words into a 128-bit block, MSB word first
module anubis_word_packer
    import anubis_io_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] word,
    input  logic              is_key,
    input  logic              accept,
    output logic [BLK_W-1:0]  block,
    output logic              tag,
    output logic              done
);
    logic [BLK_W-WORD_W-1:0] gather;
    logic [1:0] cnt;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            gather <= '0;
            cnt <= 2'd0;
            tag <= 1'b0;
        end else if (accept) begin
            gather <= {gather[BLK_W-2*WORD_W-1:0], word};
            cnt <= cnt + 2'd1;
            if (cnt == 2'd0) tag <= is_key;
        end
    // the block is complete in the same cycle its fourth word is accepted
    assign block = {gather, word};
    assign done = accept && cnt == 2'd3;
endmodule

// File: rtl/anubis_stream_ctrl.sv
// anubis_stream_ctrl: word-stream front-end that loads, runs and drains the Anubis core per block
module anubis_stream_ctrl
    import anubis_io_pkg::*;
#(
    parameter int LOAD_CYCLES = 3,
    parameter int RUN_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] s_word,
    input  logic              s_is_key,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] m_word,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              err_no_key,
    output logic              core_reset,
    output logic [1:0]        core_order,
    output logic [BLK_W-1:0]  core_data_in,
    input  logic [BLK_W-1:0]  core_data_out
);
    state_t state, state_n;
    logic [4:0] phase, phase_n;
    logic [BLK_W-1:0] key, pt, ct, blk;
    logic key_valid, tag, done;

    anubis_word_packer u_packer (
        .clk(clk),
        .reset(reset),
        .word(s_word),
        .is_key(s_is_key),
        .accept(s_valid && s_ready),
        .block(blk),
        .tag(tag),
        .done(done)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            phase <= 5'd0;
            key <= '0;
            key_valid <= 1'b0;
            pt <= '0;
            ct <= '0;
            err_no_key <= 1'b0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            err_no_key <= done && !tag && !key_valid;
            if (done && tag) begin
                key <= blk;
                key_valid <= 1'b1;
            end
            if (done && !tag && key_valid) pt <= blk;
            if (state == CAPT) ct <= core_data_out;
        end

    // in DRAIN the phase counter doubles as the slice index, 3 = MSB slice
    always_comb begin
        state_n = state;
        phase_n = phase;
        case (state)
            IDLE:  if (done && !tag && key_valid) begin state_n = CRST; phase_n = 5'd0; end
            CRST:  begin state_n = KEYLD; phase_n = 5'(LOAD_CYCLES - 1); end
            KEYLD: if (phase == 5'd0) begin state_n = PTLD; phase_n = 5'(LOAD_CYCLES - 1); end
                   else phase_n = phase - 5'd1;
            PTLD:  if (phase == 5'd0) begin state_n = RUN; phase_n = 5'(RUN_CYCLES - 1); end
                   else phase_n = phase - 5'd1;
            RUN:   if (phase == 5'd0) begin state_n = CAPT; phase_n = 5'd0; end
                   else phase_n = phase - 5'd1;
            CAPT:  begin state_n = DRAIN; phase_n = 5'd3; end
            DRAIN: if (m_ready) begin
                       if (phase == 5'd0) state_n = IDLE;
                       else phase_n = phase - 5'd1;
                   end
            default: begin state_n = IDLE; phase_n = 5'd0; end
        endcase
    end

    assign s_ready = state == IDLE && !reset;
    assign busy = state != IDLE;
    assign m_valid = state == DRAIN;
    assign m_word = m_valid ? ct[{phase[1:0], 5'd0} +: WORD_W] : '0;
    assign core_reset = state == IDLE || state == CRST;
    assign core_order = state == KEYLD ? ORD_KEY : state == PTLD ? ORD_PT : ORD_RUN;
    assign core_data_in = state == KEYLD ? key : (state == PTLD || state == RUN) ? pt : '0;
endmodule

// File: doc/anubis_stream_ctrl.md
Name: anubis_stream_ctrl

Overview:
- Streaming front-end that sits directly upstream and downstream of the 128-bit Anubis encryption core.
- Accepts 32-bit words over a valid/ready input, assembles 128-bit key and plaintext blocks, and stores the master key.
- Per block: resets the core, sequences its 2-bit order code (key load, plaintext load, run), waits a fixed run time, captures the ciphertext, and returns it as four 32-bit words over a valid/ready output.
- The key is reloaded into the core for every block, because the core overwrites its key register with round keys during encryption.

Parameters:
- LOAD_CYCLES, 3, cycles each load order (00, then 01) is held on core_order; minimum 2.
- RUN_CYCLES, 16, cycles order 10 is held before ciphertext capture; must cover 12 rounds plus core state lag.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- s_word  in  32  input word; first word of a group = bits [127:96]
- s_is_key  in  1  sampled with word 0 of a group: 1 = key group, 0 = plaintext group
- s_valid  in  1  input word valid
- s_ready  out  1  input ready
- m_word  out  32  ciphertext word; first word = bits [127:96]
- m_valid  out  1  output word valid
- m_ready  in  1  output ready
- busy  out  1  high in every state except IDLE
- err_no_key  out  1  one-cycle pulse: plaintext block dropped, no key stored
- core_reset  out  1  reset to the Anubis core
- core_order  out  2  order code to the core
- core_data_in  out  128  key or plaintext to the core
- core_data_out  in  128  ciphertext from the core

Behaviour:
- Reset values: state IDLE, word count 0, key_valid 0, s_ready 0 while reset is asserted, m_valid 0, m_word 0, busy 0, err_no_key 0, core_reset 1, core_order 2'b10, core_data_in 0.
- IDLE:
  - s_ready=1, core_reset=1, core_order=10.
  - A word is accepted on a clock edge where s_valid && s_ready; it shifts into the 128-bit gather register and the 2-bit count increments, wrapping 3->0.
  - The tag is latched on word 0 only; s_is_key on words 1-3 is ignored.
- Group complete (4th word accepted):
  - Key group: the key register is loaded, key_valid is set, state stays IDLE. No encryption starts.
  - Plaintext group with key_valid=0: block discarded, err_no_key pulses on the next cycle, state stays IDLE.
  - Plaintext group with key_valid=1: block latched, state goes to CRST.
- CRST (1 cycle): core_reset=1, s_ready=0.
- KEYLD (LOAD_CYCLES cycles): core_reset=0, core_order=00, core_data_in=key.
- PTLD (LOAD_CYCLES cycles): core_order=01, core_data_in=plaintext.
- RUN (RUN_CYCLES cycles): core_order=10, core_data_in=plaintext held.
- CAPT (1 cycle): core_data_out is registered into the output register at the end of the cycle; state goes to DRAIN.
- DRAIN:
  - m_valid=1; m_word = current 32-bit slice, MSB slice first.
  - The slice advances only on m_valid && m_ready; m_word and m_valid stay stable while m_ready=0.
  - After the 4th handshake: m_valid=0, state returns to IDLE.
  - core_order stays 10 throughout.
- Latency: last plaintext word accepted at edge E0 -> m_valid rises at edge E0 + 2 + 2*LOAD_CYCLES + RUN_CYCLES (24 with defaults).
- A new key group may be written in IDLE at any time; it affects only later blocks.
- Reset mid-operation (any state) returns everything to reset values immediately, including key_valid=0; a partial gather is discarded.
- Phase counter is 5 bits wide, loaded per state, counts down, and advances state at 0.

Decomposition:
- Package anubis_io_pkg:
  - state encoding for IDLE, CRST, KEYLD, PTLD, RUN, CAPT, DRAIN
  - order constants ORD_KEY=2'b00, ORD_PT=2'b01, ORD_RUN=2'b10
  - WORD_W=32, BLK_W=128
- Sub-module anubis_word_packer: 4x32 -> 128 gather with count, tag latch and done pulse.
- Output slicing and the FSM stay in the top module.

Test Plan:
- Key 00112233_44556677_8899AABB_CCDDEEFF, then plaintext 00000000_00000000_00000000_00000001 -> core_order sequence 00 x3, 01 x3, 10 x16; m_valid at E0+24; four m_words equal the model ciphertext, MSB slice first.
- Plaintext group sent after reset with no key -> err_no_key pulses once, no m_valid, s_ready returns to 1 next cycle.
- Two back-to-back plaintext blocks under one key -> core_data_in equals the key during each KEYLD; both outputs match the model.
- m_ready held low 5 cycles in DRAIN -> m_word 32'h(first slice) stable, m_valid stays 1, no slice skipped.
- Reset asserted in RUN -> outputs return to reset values asynchronously; the next plaintext without a new key raises err_no_key.
- Key group with s_is_key=1 on word 0 and 0 on words 1-3 -> treated as a key; no encryption starts.
